// File: rtl/ifu_prefetch_buffer.sv
// ifu_prefetch_buffer: burst-prefetching instruction FIFO between the AXI read channel and IDU
module ifu_prefetch_buffer #(
   parameter int          DEPTH     = 4,
   parameter int          BURST_LEN = 4,
   parameter logic [31:0] RESET_PC  = 32'h3000_0000,
   parameter logic [3:0]  AXI_ID    = 4'd0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_inst_err,
   output logic [31:0] o_axi_araddr,
   output logic        o_axi_arvalid,
   output logic [3:0]  o_axi_arid,
   output logic [7:0]  o_axi_arlen,
   output logic [2:0]  o_axi_arsize,
   output logic [1:0]  o_axi_arburst,
   input  logic        i_axi_arready,
   input  logic [31:0] i_axi_rdata,
   input  logic        i_axi_rvalid,
   output logic        o_axi_rready,
   input  logic [1:0]  i_axi_rresp,
   input  logic [3:0]  i_axi_rid,
   input  logic        i_axi_rlast
);
   localparam int          AW          = $clog2(DEPTH);
   localparam logic [AW:0] ISSUE_LIMIT = (AW+1)'(DEPTH - BURST_LEN);
   localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_LEN);
   localparam logic [1:0]  IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DRAIN = 2'd3;

   logic [1:0]    state;
   logic          stale;
   logic [31:0]   fetch_pc, head_pc;
   logic [31:0]   mem_inst [DEPTH];
   logic          mem_err  [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push, pop, last_beat, unused_rid;

   assign last_beat     = i_axi_rvalid && i_axi_rlast;
   assign push          = state == DATA && i_axi_rvalid && !i_redirect;
   assign pop           = o_valid && i_ready && !i_redirect;
   assign unused_rid    = ^i_axi_rid;
   assign o_valid       = count != '0;
   assign o_inst        = mem_inst[rd_ptr];
   assign o_inst_err    = mem_err[rd_ptr];
   assign o_pc          = head_pc;
   assign o_axi_arvalid = state == ADDR;
   assign o_axi_rready  = state == DATA || state == DRAIN;
   assign o_axi_arid    = AXI_ID;
   assign o_axi_arlen   = 8'(BURST_LEN - 1);
   assign o_axi_arsize  = 3'b010;
   assign o_axi_arburst = 2'b01;

   // Fetch FSM: issue a burst only when it fits entirely, discard bursts made stale by a redirect
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= IDLE;
         stale        <= 1'b0;
         fetch_pc     <= RESET_PC;
         o_axi_araddr <= RESET_PC;
      end else begin
         case (state)
            IDLE:
               if (!i_redirect && count <= ISSUE_LIMIT) begin
                  state        <= ADDR;
                  o_axi_araddr <= fetch_pc;
               end
            ADDR:
               if (i_axi_arready) begin
                  state <= (stale || i_redirect) ? DRAIN : DATA;
                  stale <= 1'b0;
               end else if (i_redirect) stale <= 1'b1;
            DATA:
               if (last_beat) state <= IDLE;
               else if (i_redirect) state <= DRAIN;
            default:
               if (last_beat) state <= IDLE;
         endcase
         if (i_redirect) fetch_pc <= i_redirect_pc;
         else if (state == DATA && last_beat) fetch_pc <= fetch_pc + BURST_BYTES;
      end
   end

   // Storage array: written only on beats that are kept
   always_ff @(posedge i_clock) begin
      if (push) begin
         mem_inst[wr_ptr] <= i_axi_rdata;
         mem_err[wr_ptr]  <= i_axi_rresp != 2'b00;
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue
   always_ff @(posedge i_clock) begin
      if (i_reset || i_redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Head PC tracks the instruction at the FIFO head
   always_ff @(posedge i_clock) begin
      if (i_reset) head_pc <= RESET_PC;
      else if (i_redirect) head_pc <= i_redirect_pc;
      else if (pop) head_pc <= head_pc + 32'd4;
   end
endmodule

// File: tb/tb_ifu_prefetch_buffer.sv
// tb_ifu_prefetch_buffer: AXI memory model plus scoreboard around the prefetch buffer
module tb_ifu_prefetch_buffer;
   localparam int BL = 4;

   logic        clk = 0, rst = 1, redirect = 0, ready = 0, arready = 0;
   logic [31:0] redirect_pc = 0, rdata = 0;
   logic        rvalid = 0, rlast = 0;
   logic [1:0]  rresp = 0;
   logic [31:0] inst, pc, araddr;
   logic        valid, inst_err, arvalid, rready;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;

   typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic err;} exp_t;
   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] ar_pend[$], ar_log[$], pop_log[$];
   logic        err_log[$];
   logic [31:0] err_addr = 32'h1, mem_base = 0;
   logic        ar_stale = 0, r_hs = 0, busy = 0;
   int          mem_idx = 0;
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   ifu_prefetch_buffer dut (
      .i_clock(clk), .i_reset(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_valid(valid), .i_ready(ready), .o_inst(inst), .o_pc(pc), .o_inst_err(inst_err),
      .o_axi_araddr(araddr), .o_axi_arvalid(arvalid), .o_axi_arid(arid), .o_axi_arlen(arlen),
      .o_axi_arsize(arsize), .o_axi_arburst(arburst), .i_axi_arready(arready),
      .i_axi_rdata(rdata), .i_axi_rvalid(rvalid), .o_axi_rready(rready), .i_axi_rresp(rresp),
      .i_axi_rid(4'd0), .i_axi_rlast(rlast)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // Scoreboard: predict a burst at AR handshake, compare on each pop, forget on redirect
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete(); ar_pend.delete(); ar_log.delete(); pop_log.delete(); err_log.delete();
         ar_stale = 0;
         r_hs = 0;
      end else begin
         if (redirect) begin
            exp_q.delete(); pop_log.delete(); err_log.delete();
         end else if (valid && ready) begin
            total++;
            pop_log.push_back(pc);
            err_log.push_back(inst_err);
            if (exp_q.size() == 0) $display("FAIL pop_unexpected: got pc=%h inst=%h, required no pop", pc, inst);
            else begin
               e = exp_q.pop_front();
               if (pc !== e.pc || inst !== e.inst || inst_err !== e.err)
                  $display("FAIL pop_data: got pc=%h inst=%h err=%b, required pc=%h inst=%h err=%b",
                           pc, inst, inst_err, e.pc, e.inst, e.err);
               else passed++;
            end
         end
         if (arvalid && arready) begin
            ar_log.push_back(araddr);
            ar_pend.push_back(araddr);
            if (!redirect && !ar_stale)
               for (int i = 0; i < BL; i++)
                  exp_q.push_back({araddr + 32'(4*i), mem_word(araddr + 32'(4*i)), (araddr + 32'(4*i)) == err_addr});
            ar_stale = 0;
         end else if (arvalid && redirect) ar_stale = 1;
         r_hs = rvalid && rready;
      end
   end

   // AXI read slave: one burst at a time, first beat one cycle after the AR handshake
   always @(posedge clk) begin
      #1;
      if (rst) begin
         busy = 0;
         mem_idx = 0;
      end else begin
         if (r_hs) begin
            if (mem_idx == BL-1) busy = 0;
            else mem_idx++;
         end
         if (!busy && ar_pend.size() > 0) begin
            busy = 1;
            mem_base = ar_pend.pop_front();
            mem_idx = 0;
         end
      end
      rvalid = busy;
      rdata  = mem_word(mem_base + 32'(4*mem_idx));
      rresp  = (busy && mem_base + 32'(4*mem_idx) == err_addr) ? 2'b10 : 2'b00;
      rlast  = busy && mem_idx == BL-1;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic rdy, input logic arr);
      rst = 1; redirect = 0; ready = rdy; arready = arr;
      repeat (2) step();
      rst = 0;
   endtask

   task automatic wait_ars(input int n, output logic ok);
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk); #1;
         ok = ar_log.size() >= n;
      end
   endtask

   task automatic wait_pops(input int n, output logic ok);
      ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk); #1;
         ok = pop_log.size() >= n;
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) step();
      total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid); else passed++;
      total++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b, required 0", arvalid); else passed++;
      total++; if (rready !== 1'b0) $display("FAIL reset_rready: got %b, required 0", rready); else passed++;
      total++; if (pc !== 32'h3000_0000) $display("FAIL reset_pc: got %h, required 30000000", pc); else passed++;
      total++; if (arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'd0)
         $display("FAIL ar_consts: got size=%b burst=%b id=%h, required 010 01 0", arsize, arburst, arid); else passed++;
      total++; if (arlen !== 8'd3) $display("FAIL arlen: got %0d, required 3", arlen); else passed++;
   endtask

   task automatic test_sequential();
      logic ok;
      do_reset(1, 1);
      wait_ars(2, ok);
      total++; if (!ok) $display("FAIL seq_ar_timeout: got %0d ARs, required 2", ar_log.size()); else passed++;
      total++; if (ar_log[0] !== 32'h3000_0000) $display("FAIL seq_ar0: got %h, required 30000000", ar_log[0]); else passed++;
      total++; if (ar_log[1] !== 32'h3000_0010) $display("FAIL seq_ar1: got %h, required 30000010", ar_log[1]); else passed++;
      wait_pops(4, ok);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (pop_log[i] !== 32'h3000_0000 + 32'(4*i)) $display("FAIL seq_pc%0d: got %h, required %h", i, pop_log[i], 32'h3000_0000 + 32'(4*i));
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic ok;
      do_reset(0, 1);
      repeat (20) step();
      total++; if (ar_log.size() != 1) $display("FAIL bp_ar_count: got %0d, required 1", ar_log.size()); else passed++;
      total++; if (valid !== 1'b1) $display("FAIL bp_valid: got %b, required 1", valid); else passed++;
      total++; if (pc !== 32'h3000_0000) $display("FAIL bp_head_pc: got %h, required 30000000", pc); else passed++;
      ready = 1;
      wait_pops(8, ok);
      total++; if (!ok) $display("FAIL bp_pop_timeout: got %0d pops, required 8", pop_log.size()); else passed++;
      total++; if (pop_log[0] !== 32'h3000_0000) $display("FAIL bp_first_pc: got %h, required 30000000", pop_log[0]); else passed++;
      for (int i = 1; i < 8; i++) begin
         total++;
         if (pop_log[i] !== pop_log[i-1] + 32'd4) $display("FAIL bp_order%0d: got %h, required %h", i, pop_log[i], pop_log[i-1] + 32'd4);
         else passed++;
      end
   endtask

   task automatic test_redirect_data();
      logic ok;
      int   n;
      do_reset(1, 1);
      n = 0;
      while (!(rvalid && mem_idx == 1) && n < 50) begin step(); n++; end
      total++; if (n >= 50) $display("FAIL rd_beat_timeout: got no beat 2, required one"); else passed++;
      redirect = 1; redirect_pc = 32'h8000_0100;
      step();
      redirect = 0;
      total++; if (valid !== 1'b0) $display("FAIL rd_flush_valid: got %b, required 0", valid); else passed++;
      wait_ars(2, ok);
      total++; if (ar_log[1] !== 32'h8000_0100) $display("FAIL rd_new_ar: got %h, required 80000100", ar_log[1]); else passed++;
      wait_pops(5, ok);
      total++; if (pop_log[0] !== 32'h8000_0100) $display("FAIL rd_first_pc: got %h, required 80000100", pop_log[0]); else passed++;
   endtask

   task automatic test_redirect_addr();
      logic ok;
      int   n;
      do_reset(1, 0);
      n = 0;
      while (!arvalid && n < 20) begin step(); n++; end
      redirect = 1; redirect_pc = 32'h8000_0200;
      step();
      redirect = 0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (arvalid !== 1'b1 || araddr !== 32'h3000_0000)
            $display("FAIL ra_stable%0d: got arvalid=%b araddr=%h, required 1 30000000", i, arvalid, araddr);
         else passed++;
         step();
      end
      arready = 1;
      wait_ars(2, ok);
      total++; if (ar_log[0] !== 32'h3000_0000) $display("FAIL ra_old_ar: got %h, required 30000000", ar_log[0]); else passed++;
      total++; if (ar_log[1] !== 32'h8000_0200) $display("FAIL ra_new_ar: got %h, required 80000200", ar_log[1]); else passed++;
      wait_pops(4, ok);
      total++; if (pop_log[0] !== 32'h8000_0200) $display("FAIL ra_first_pc: got %h, required 80000200", pop_log[0]); else passed++;
   endtask

   task automatic test_error();
      logic ok;
      err_addr = 32'h3000_0000;
      do_reset(1, 1);
      wait_pops(5, ok);
      total++; if (err_log[0] !== 1'b1) $display("FAIL err_beat1: got %b, required 1", err_log[0]); else passed++;
      for (int i = 1; i < 4; i++) begin
         total++; if (err_log[i] !== 1'b0) $display("FAIL err_beat%0d: got %b, required 0", i+1, err_log[i]); else passed++;
      end
      total++; if (pop_log[4] !== 32'h3000_0010) $display("FAIL err_continue: got %h, required 30000010", pop_log[4]); else passed++;
      err_addr = 32'h1;
   endtask

   task automatic test_wrap();
      logic ok;
      do_reset(1, 1);
      redirect = 1; redirect_pc = 32'hFFFF_FFF0;
      step();
      redirect = 0;
      wait_ars(2, ok);
      total++; if (ar_log[0] !== 32'hFFFF_FFF0) $display("FAIL wrap_ar0: got %h, required fffffff0", ar_log[0]); else passed++;
      total++; if (ar_log[1] !== 32'h0000_0000) $display("FAIL wrap_ar1: got %h, required 00000000", ar_log[1]); else passed++;
      wait_pops(8, ok);
      total++; if (pop_log[3] !== 32'hFFFF_FFFC) $display("FAIL wrap_pc3: got %h, required fffffffc", pop_log[3]); else passed++;
      total++; if (pop_log[4] !== 32'h0000_0000) $display("FAIL wrap_pc4: got %h, required 00000000", pop_log[4]); else passed++;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_data();
      test_redirect_addr();
      test_error();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
